// File: rtl/unsigned_approx_mul_pipe_if.sv
// unsigned_approx_mul_pipe_if: valid/ready operand and result bundle for the approximate multiplier
interface unsigned_approx_mul_pipe_if #(parameter int W = 8);
  logic in_valid, in_ready, exact, out_valid, out_ready, out_exact;
  logic [W-1:0] x, y;
  logic [2*W-1:0] z;
  modport master (output in_valid, x, y, exact, out_ready, input in_ready, out_valid, z, out_exact);
  modport slave (input in_valid, x, y, exact, out_ready, output in_ready, out_valid, z, out_exact);
endinterface

// File: rtl/unsigned_approx_mul_pipe.sv
// unsigned_approx_mul_pipe: two-stage valid/ready multiplier with truncated approximate low rows
module unsigned_approx_mul_pipe #(
  parameter int W = 8,
  parameter int L = 4,
  parameter int T = 7
) (
  input logic clk,
  input logic rst,
  unsigned_approx_mul_pipe_if.slave bus
);
  localparam int N = 2 * W;
  localparam logic [N-1:0] T_MASK = {N{1'b1}} << T;
  logic [W-1:0] pp [W];
  logic [N-1:0] hi, lo, s1_hi, s1_lo;
  logic s1_valid, s1_exact, ld1, ld2;
  assign ld2 = !bus.out_valid || bus.out_ready;
  assign ld1 = !s1_valid || ld2;
  assign bus.in_ready = ld1;
  // rows below L only enter the high sum in exact mode; in approximate mode they are paired and truncated
  always_comb begin
    hi = '0;
    lo = '0;
    for (int i = 0; i < W; i++) begin
      pp[i] = bus.y & {W{bus.x[i]}};
      hi = (bus.exact || i >= L) ? hi + (N'(pp[i]) << i) : hi;
    end
    for (int k = 0; k < L / 2; k++)
      lo = lo + (((N'(pp[2*k]) << (2*k)) | (N'(pp[2*k+1]) << (2*k+1))) & T_MASK);
    lo = bus.exact ? '0 : lo;
  end
  always_ff @(posedge clk)
    if (rst) begin
      s1_valid <= 1'b0;
      s1_exact <= 1'b0;
      s1_hi <= '0;
      s1_lo <= '0;
      bus.out_valid <= 1'b0;
      bus.out_exact <= 1'b0;
      bus.z <= '0;
    end else begin
      if (ld1) begin
        s1_valid <= bus.in_valid;
        s1_exact <= bus.exact;
        s1_hi <= hi;
        s1_lo <= lo;
      end
      if (ld2) begin
        bus.out_valid <= s1_valid;
        if (s1_valid) begin
          bus.z <= s1_hi + s1_lo;
          bus.out_exact <= s1_exact;
        end
      end
    end
endmodule

// File: tb/tb_unsigned_approx_mul_pipe.sv
// tb_unsigned_approx_mul_pipe: randomized and directed checks against a column-level product model
module tb_unsigned_approx_mul_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  unsigned_approx_mul_pipe_if #(.W(8)) a_if ();
  unsigned_approx_mul_pipe_if #(.W(12)) b_if ();
  unsigned_approx_mul_pipe #(.W(8), .L(4), .T(7)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  unsigned_approx_mul_pipe #(.W(12), .L(0), .T(7)) dut_b (.clk(clk), .rst(rst), .bus(b_if));
  int n_cmp = 0;
  int n_bad = 0;
  logic [16:0] qa[$];

  function automatic longint model(int w, int l, int t, longint xv, longint yv, bit ex);
    longint r, a;
    r = ex ? xv * yv : yv * ((xv >> l) << l);
    if (!ex)
      for (int k = 0; k < l / 2; k++) begin
        a = 0;
        for (int j = 0; j < w; j++)
          for (int s = 0; s < 2; s++)
            if (xv[2*k+s] && yv[j] && (2*k + s + j) >= t) a = a | (longint'(1) << (2*k + s + j));
        r = r + a;
      end
    return r & ((longint'(1) << (2 * w)) - 1);
  endfunction

  task automatic drive_a(input logic v, input logic [7:0] xv, input logic [7:0] yv, input logic ex, input logic ordy);
    a_if.in_valid = v;
    a_if.x = xv;
    a_if.y = yv;
    a_if.exact = ex;
    a_if.out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_a(0, 0, 0, 0, 1);
    tick();
    n_cmp++; if (a_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", a_if.out_valid); end
    n_cmp++; if (a_if.z !== 16'h0) begin n_bad++; $display("FAIL reset_z: got %h want 0000", a_if.z); end
    n_cmp++; if (a_if.out_exact !== 1'b0) begin n_bad++; $display("FAIL reset_out_exact: got %b want 0", a_if.out_exact); end
    rst = 1'b0;
    tick();
    n_cmp++; if (a_if.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", a_if.in_ready); end
  endtask

  task automatic test_directed();
    logic [7:0] tx[4] = '{8'hFF, 8'hFF, 8'h0F, 8'h10};
    logic [7:0] ty[4] = '{8'hFF, 8'hFF, 8'h10, 8'h10};
    logic te[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] tz[4] = '{16'hFE01, 16'hF810, 16'h0080, 16'h0100};
    logic want_v;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive_a(1, tx[i], ty[i], te[i], 1);
      else drive_a(0, 0, 0, 0, 1);
      want_v = (i >= 2 && i < 6);
      n_cmp++;
      if (a_if.out_valid !== want_v) begin n_bad++; $display("FAIL directed_valid[%0d]: got %b want %b", i, a_if.out_valid, want_v); end
      if (want_v) begin
        n_cmp++;
        if ({a_if.out_exact, a_if.z} !== {te[i-2], tz[i-2]})
          begin n_bad++; $display("FAIL directed_z[%0d]: got %b/%h want %b/%h", i - 2, a_if.out_exact, a_if.z, te[i-2], tz[i-2]); end
      end
      tick();
    end
  endtask

  task automatic test_stream();
    int got = 0;
    logic [7:0] xv, yv;
    logic ex;
    logic [16:0] e;
    for (int i = 0; i < 103; i++) begin
      xv = 8'($urandom);
      yv = 8'($urandom);
      ex = 1'($urandom_range(0, 1));
      drive_a(i < 100, xv, yv, ex, 1);
      if (i < 100) begin
        n_cmp++;
        if (a_if.in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, a_if.in_ready); end
      end
      if (a_if.out_valid && a_if.out_ready) begin
        n_cmp++; got++;
        if (qa.size() == 0) begin n_bad++; $display("FAIL stream_extra: got %h want none", a_if.z); end
        else begin
          e = qa.pop_front();
          if ({a_if.out_exact, a_if.z} !== e) begin n_bad++; $display("FAIL stream_z: got %b/%h want %b/%h", a_if.out_exact, a_if.z, e[16], e[15:0]); end
        end
      end
      if (a_if.in_valid && a_if.in_ready) qa.push_back({ex, 16'(model(8, 4, 7, longint'(xv), longint'(yv), ex))});
      tick();
    end
    n_cmp++;
    if (got !== 100 || qa.size() != 0) begin n_bad++; $display("FAIL stream_count: got %0d left %0d want 100 left 0", got, qa.size()); end
  endtask

  task automatic test_backpressure();
    int acc = 0, got = 0;
    logic [7:0] xv, yv;
    logic ex, stall;
    bit have = 0;
    logic [16:0] held, e;
    qa.delete();
    for (int i = 0; i < 20; i++) begin
      stall = (i < 5);
      xv = 8'($urandom);
      yv = 8'($urandom);
      ex = 1'($urandom_range(0, 1));
      drive_a(stall, xv, yv, ex, !stall);
      if (stall && i >= 2) begin
        n_cmp++;
        if (a_if.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, a_if.in_ready); end
      end
      if (stall && a_if.out_valid) begin
        if (!have) begin held = {a_if.out_exact, a_if.z}; have = 1; end
        else begin
          n_cmp++;
          if ({a_if.out_exact, a_if.z} !== held) begin n_bad++; $display("FAIL bp_hold[%0d]: got %h want %h", i, {a_if.out_exact, a_if.z}, held); end
        end
      end
      if (a_if.out_valid && a_if.out_ready) begin
        n_cmp++; got++;
        if (qa.size() == 0) begin n_bad++; $display("FAIL bp_extra: got %h want none", a_if.z); end
        else begin
          e = qa.pop_front();
          if ({a_if.out_exact, a_if.z} !== e) begin n_bad++; $display("FAIL bp_z: got %b/%h want %b/%h", a_if.out_exact, a_if.z, e[16], e[15:0]); end
        end
      end
      if (a_if.in_valid && a_if.in_ready) begin
        qa.push_back({ex, 16'(model(8, 4, 7, longint'(xv), longint'(yv), ex))});
        acc++;
      end
      tick();
    end
    n_cmp++; if (acc !== 2) begin n_bad++; $display("FAIL bp_accepted: got %0d want 2", acc); end
    n_cmp++; if (got !== 2 || qa.size() != 0) begin n_bad++; $display("FAIL bp_delivered: got %0d left %0d want 2 left 0", got, qa.size()); end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 2; i++) begin
      drive_a(1, 8'hFF, 8'hFF, 1, 0);
      tick();
    end
    rst = 1'b1;
    drive_a(0, 0, 0, 0, 0);
    tick();
    n_cmp++; if (a_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid: got %b want 0", a_if.out_valid); end
    n_cmp++; if (a_if.z !== 16'h0) begin n_bad++; $display("FAIL mid_reset_z: got %h want 0000", a_if.z); end
    n_cmp++; if (a_if.out_exact !== 1'b0) begin n_bad++; $display("FAIL mid_reset_exact: got %b want 0", a_if.out_exact); end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_a(0, 0, 0, 0, 1);
      n_cmp++;
      if (a_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_stale[%0d]: got %b/%h want no result", i, a_if.out_valid, a_if.z); end
      tick();
    end
  endtask

  task automatic test_sweep();
    logic [23:0] qb[$];
    logic [23:0] e;
    logic [11:0] xv, yv;
    int got = 0;
    for (int i = 0; i < 62; i++) begin
      xv = 12'($urandom);
      yv = 12'($urandom);
      b_if.in_valid = (i < 60);
      b_if.x = xv;
      b_if.y = yv;
      b_if.exact = 1'b0;
      b_if.out_ready = 1'b1;
      #1;
      if (b_if.out_valid) begin
        n_cmp++; got++;
        e = (qb.size() == 0) ? 24'hx : qb.pop_front();
        if (b_if.z !== e) begin n_bad++; $display("FAIL sweep_z: got %h want %h", b_if.z, e); end
      end
      if (b_if.in_valid && b_if.in_ready) qb.push_back(24'(xv) * 24'(yv));
      tick();
    end
    n_cmp++; if (got !== 60) begin n_bad++; $display("FAIL sweep_count: got %0d want 60", got); end
  endtask

  initial begin
    rst = 1'b1;
    b_if.in_valid = 1'b0;
    b_if.x = '0;
    b_if.y = '0;
    b_if.exact = 1'b0;
    b_if.out_ready = 1'b1;
    drive_a(0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_stream();
    test_backpressure();
    test_reset_midflight();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
